// File: rtl/ahb_burst_master.sv
// Command-driven AHB burst master: requests the bus, drives NONSEQ/SEQ beats with a
// pipelined data phase, and resumes as INCR after a mid-burst loss of grant.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [4:0]        cmd_len,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              Hbusreq,
    input  logic              Hgrant,
    input  logic              Hready,
    input  logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Htrans,
    output logic [ADDR_W-1:0] Haddr,
    output logic [2:0]        Hburst,
    output logic              Hwrite,
    output logic [2:0]        Hsize,
    output logic [DATA_W-1:0] Hwdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_LAST} state_e;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          cburst_q, cburst_d;
    logic [2:0]          hburst_q, hburst_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [4:0]          beats_q, beats_d;
    logic                first_q, first_d;
    logic                dp_valid_q, dp_valid_d;
    logic                dp_write_q, dp_write_d;
    logic                dp_last_q, dp_last_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;

    logic [4:0]          n_beats;
    logic [4:0]          wrap_n;
    logic [ADDR_W-1:0]   addr_incr;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   next_addr;

    always_comb begin
        case (cmd_burst)
            3'b000:         n_beats = 5'd1;
            3'b001:         n_beats = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
            3'b010, 3'b011: n_beats = 5'd4;
            3'b100, 3'b101: n_beats = 5'd8;
            default:        n_beats = 5'd16;
        endcase
    end

    // Address sequence follows the original command burst even after an INCR resume,
    // so a resumed WRAP still touches the same set of addresses.
    always_comb begin
        case (cburst_q)
            3'b010:  wrap_n = 5'd4;
            3'b100:  wrap_n = 5'd8;
            3'b110:  wrap_n = 5'd16;
            default: wrap_n = 5'd0;
        endcase
        addr_incr = addr_q + (ADDR_W'(1) << size_q);
        wrap_mask = (ADDR_W'(wrap_n) << size_q) - ADDR_W'(1);
        if (wrap_n != 5'd0) begin
            next_addr = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
        end else begin
            next_addr = addr_incr;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cburst_d   = cburst_q;
        hburst_d   = hburst_q;
        write_d    = write_q;
        size_d     = size_q;
        beats_d    = beats_q;
        first_d    = first_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_last_d  = dp_last_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        cmd_ready  = 1'b0;
        Hbusreq    = 1'b0;
        Htrans     = HT_IDLE;
        wr_pop     = 1'b0;

        // Data phase of the previous beat retires on any Hready edge, independent of state.
        if (dp_valid_q && Hready) begin
            dp_valid_d = 1'b0;
            if (!dp_write_q) begin
                rd_data_d  = Hrdata;
                rd_valid_d = 1'b1;
            end
            if (dp_last_q) begin
                done_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    cburst_d = cmd_burst;
                    hburst_d = cmd_burst;
                    write_d  = cmd_write;
                    size_d   = cmd_size;
                    beats_d  = n_beats;
                    first_d  = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                Hbusreq = 1'b1;
                if (Hgrant && Hready) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                Htrans  = first_q ? HT_NONSEQ : HT_SEQ;
                Hbusreq = (beats_q > 5'd1);
                if (Hready) begin
                    dp_valid_d = 1'b1;
                    dp_write_d = write_q;
                    dp_last_d  = (beats_q == 5'd1);
                    if (write_q) begin
                        hwdata_d = wr_data;
                        wr_pop   = 1'b1;
                    end
                    addr_d  = next_addr;
                    beats_d = beats_q - 5'd1;
                    first_d = 1'b0;
                    if (beats_q == 5'd1) begin
                        state_d = S_LAST;
                    end else if (!Hgrant) begin
                        first_d  = 1'b1;
                        hburst_d = HB_INCR;
                        state_d  = S_REQ;
                    end
                end
            end
            S_LAST: begin
                if (dp_valid_q && Hready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cburst_q   <= '0;
            hburst_q   <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            beats_q    <= '0;
            first_q    <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_last_q  <= 1'b0;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cburst_q   <= cburst_d;
            hburst_q   <= hburst_d;
            write_q    <= write_d;
            size_q     <= size_d;
            beats_q    <= beats_d;
            first_q    <= first_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_last_q  <= dp_last_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign Haddr    = addr_q;
    assign Hburst   = hburst_q;
    assign Hwrite   = write_q;
    assign Hsize    = size_q;
    assign Hwdata   = hwdata_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Self-checking bench for ahb_burst_master: directed vector table, grant-loss and
// reset sequences, and randomized commands against a transaction-level scoreboard.
module tb_ahb_burst_master;

    logic        Hclk, Hresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst, cmd_size;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data, rd_data, Hrdata, Haddr, Hwdata;
    logic        wr_pop, rd_valid, done, Hbusreq, Hgrant, Hready, Hwrite;
    logic [1:0]  Htrans;
    logic [2:0]  Hburst, Hsize;

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .Hbusreq(Hbusreq), .Hgrant(Hgrant), .Hready(Hready),
        .Hrdata(Hrdata), .Htrans(Htrans), .Haddr(Haddr), .Hburst(Hburst), .Hwrite(Hwrite),
        .Hsize(Hsize), .Hwdata(Hwdata)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference state
    bit          m_active, m_req, m_addr_ph, m_nonseq, m_resumed, m_write;
    int          m_k, m_n;
    logic [2:0]  m_burst, m_size;
    logic [31:0] addr_list [16];
    bit          dp_pend, dp_write, dp_last, exp_rv, exp_done;
    logic [31:0] dp_wdata, exp_rdata;

    int          obs_cnt, done_cnt;
    logic [31:0] obs_addr [32];
    logic [1:0]  obs_trans [32];
    logic [2:0]  obs_burst [32];

    bit rnd_mode;
    int stall_beat, stall_cycles, stall_cnt, drop_beat, drop_cycles, gcnt, abort_beat;

    function automatic int beats_of(input logic [2:0] b, input logic [4:0] len);
        case (b)
            3'd0:       return 1;
            3'd1:       return (len == 0) ? 1 : int'(len);
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic build_addrs(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s, input int n);
        int unsigned sz, bnd, base, off;
        sz = 1 << s;
        if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
            bnd  = n * sz;
            off  = a % bnd;
            base = a - off;
            for (int k = 0; k < n; k++) addr_list[k] = base + ((off + k * sz) % bnd);
        end else begin
            for (int k = 0; k < n; k++) addr_list[k] = a + k * sz;
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_req = 0; m_addr_ph = 0; m_nonseq = 0; m_resumed = 0;
        m_k = 0; m_n = 0; dp_pend = 0; exp_rv = 0; exp_done = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_Hbusreq"}, Hbusreq, 0);
        chk({tag, "_Htrans"}, Htrans, 0);
        chk({tag, "_Haddr"}, Haddr, 0);
        chk({tag, "_Hburst"}, Hburst, 0);
        chk({tag, "_Hwrite"}, Hwrite, 0);
        chk({tag, "_Hsize"}, Hsize, 0);
        chk({tag, "_Hwdata"}, Hwdata, 0);
        chk({tag, "_wr_pop"}, wr_pop, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic one_cycle(input bit offer);
        bit acc, cmd_acc, pre_active;
        @(posedge Hclk);
        #1;
        pre_active = m_active;
        cmd_valid = offer;
        wr_data = $urandom;
        Hrdata  = $urandom;
        if (rnd_mode) begin
            Hready = ($urandom_range(0, 3) != 0);
            Hgrant = ($urandom_range(0, 4) != 0);
        end else begin
            Hready = 1'b1;
            Hgrant = 1'b1;
            if (m_addr_ph && m_k == stall_beat && stall_cnt < stall_cycles) begin
                Hready = 1'b0;
                stall_cnt++;
            end
            if (gcnt > 0) begin
                Hgrant = 1'b0;
                gcnt--;
            end else if (m_addr_ph && m_k == drop_beat) begin
                Hgrant = 1'b0;
                gcnt = drop_cycles;
                drop_beat = -1;
            end
        end
        #1;
        chk("cmd_ready", cmd_ready, !pre_active);
        chk("Hbusreq", Hbusreq, m_addr_ph ? (m_k < m_n - 1) : (m_active && m_k < m_n));
        chk("addr_phase", Htrans != 2'b00, m_addr_ph);
        if (m_addr_ph) begin
            chk("Htrans", Htrans, m_nonseq ? 2'b10 : 2'b11);
            chk("Haddr", Haddr, addr_list[m_k]);
            chk("Hburst", Hburst, m_resumed ? 3'b001 : m_burst);
            chk("Hwrite", Hwrite, m_write);
            chk("Hsize", Hsize, m_size);
        end
        acc = m_addr_ph && Hready;
        chk("wr_pop", wr_pop, acc && m_write);
        chk("done", done, exp_done);
        chk("rd_valid", rd_valid, exp_rv);
        if (exp_rv) chk("rd_data", rd_data, exp_rdata);
        if (dp_pend && dp_write) chk("Hwdata", Hwdata, dp_wdata);
        if (done) done_cnt++;

        exp_done = 0;
        exp_rv = 0;
        if (dp_pend && Hready) begin
            if (!dp_write) begin
                exp_rv = 1;
                exp_rdata = Hrdata;
            end
            if (dp_last) begin
                exp_done = 1;
                m_active = 0;
            end
            dp_pend = 0;
        end
        cmd_acc = offer && !pre_active;
        if (acc) begin
            if (obs_cnt < 32) begin
                obs_addr[obs_cnt]  = Haddr;
                obs_trans[obs_cnt] = Htrans;
                obs_burst[obs_cnt] = Hburst;
            end
            obs_cnt++;
            dp_pend  = 1;
            dp_write = m_write;
            dp_wdata = wr_data;
            dp_last  = (m_k == m_n - 1);
            m_k++;
            if (m_k == m_n) begin
                m_addr_ph = 0;
            end else if (!Hgrant) begin
                m_addr_ph = 0;
                m_req = 1;
                m_resumed = 1;
                m_nonseq = 1;
            end else begin
                m_nonseq = 0;
            end
        end else if (!m_addr_ph && m_req && Hgrant && Hready) begin
            m_addr_ph = 1;
            m_req = 0;
        end
        if (cmd_acc) begin
            m_active = 1; m_req = 1; m_addr_ph = 0; m_k = 0; m_nonseq = 1; m_resumed = 0;
            m_n = beats_of(cmd_burst, cmd_len);
            m_burst = cmd_burst; m_write = cmd_write; m_size = cmd_size;
            build_addrs(cmd_addr, cmd_burst, cmd_size, m_n);
        end
    endtask

    task automatic run_cmd(input logic [2:0] b, input logic [4:0] len, input logic [2:0] s,
                           input logic w, input logic [31:0] a);
        int done0, n;
        bit finished;
        cmd_burst = b; cmd_len = len; cmd_size = s; cmd_write = w; cmd_addr = a;
        n = beats_of(b, len);
        obs_cnt = 0;
        stall_cnt = 0;
        done0 = done_cnt;
        finished = 0;
        one_cycle(1'b1);
        for (int c = 0; c < 400 && !finished; c++) begin
            one_cycle(1'b0);
            if (abort_beat >= 0 && m_k >= abort_beat) return;
            if (done) finished = 1;
        end
        chk("cmd_completed", finished, 1);
        chk("beat_count", obs_cnt, n);
        chk("done_count", done_cnt - done0, 1);
    endtask

    typedef struct {
        logic [2:0]       burst;
        logic [4:0]       len;
        logic [2:0]       size;
        logic             write;
        logic [31:0]      addr;
        int               stall_beat;
        int               stall_cycles;
        int               exp_beats;
        logic [3:0][31:0] exp_a;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [2:0] b, input logic [4:0] l, input logic [2:0] s,
                                input logic w, input logic [31:0] a, input int sb, input int sc,
                                input int nb, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.burst = b; v.len = l; v.size = s; v.write = w; v.addr = a;
        v.stall_beat = sb; v.stall_cycles = sc; v.exp_beats = nb;
        v.exp_a[0] = a0; v.exp_a[1] = a1; v.exp_a[2] = a2; v.exp_a[3] = a3;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(3'b011, 5'd0, 3'd2, 1'b1, 32'h100, -1, 0, 4,  32'h100, 32'h104, 32'h108, 32'h10C);
        vecs[1] = mk(3'b010, 5'd0, 3'd2, 1'b0, 32'h108, -1, 0, 4,  32'h108, 32'h10C, 32'h100, 32'h104);
        vecs[2] = mk(3'b101, 5'd0, 3'd2, 1'b1, 32'h040,  2, 2, 8,  32'h040, 32'h044, 32'h048, 32'h04C);
        vecs[3] = mk(3'b100, 5'd0, 3'd1, 1'b0, 32'h03C, -1, 0, 8,  32'h03C, 32'h03E, 32'h030, 32'h032);
        vecs[4] = mk(3'b000, 5'd0, 3'd0, 1'b1, 32'h020, -1, 0, 1,  32'h020, 32'h0,   32'h0,   32'h0);
        vecs[5] = mk(3'b001, 5'd0, 3'd2, 1'b0, 32'h080, -1, 0, 1,  32'h080, 32'h0,   32'h0,   32'h0);
        vecs[6] = mk(3'b001, 5'd3, 3'd0, 1'b1, 32'h010,  0, 1, 3,  32'h010, 32'h011, 32'h012, 32'h0);
        vecs[7] = mk(3'b110, 5'd0, 3'd0, 1'b0, 32'h007, -1, 0, 16, 32'h007, 32'h008, 32'h009, 32'h00A);

        Hresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_len = '0;
        cmd_write = 1'b0; cmd_size = '0; wr_data = '0; Hrdata = '0; Hgrant = 1'b1; Hready = 1'b1;
        rnd_mode = 0; stall_beat = -1; stall_cycles = 0; drop_beat = -1; drop_cycles = 0;
        gcnt = 0; abort_beat = -1; done_cnt = 0;
        model_reset();

        repeat (3) @(posedge Hclk);
        #1;
        check_reset("reset");
        @(negedge Hclk);
        Hresetn = 1'b1;
        one_cycle(1'b0);

        foreach (vecs[i]) begin
            stall_beat = vecs[i].stall_beat;
            stall_cycles = vecs[i].stall_cycles;
            run_cmd(vecs[i].burst, vecs[i].len, vecs[i].size, vecs[i].write, vecs[i].addr);
            chk($sformatf("vec%0d_beats", i), obs_cnt, vecs[i].exp_beats);
            for (int k = 0; k < 4 && k < vecs[i].exp_beats; k++)
                chk($sformatf("vec%0d_addr%0d", i, k), obs_addr[k], vecs[i].exp_a[k]);
            chk($sformatf("vec%0d_first_nonseq", i), obs_trans[0], 2'b10);
            if (vecs[i].exp_beats > 1) chk($sformatf("vec%0d_second_seq", i), obs_trans[1], 2'b11);
        end
        stall_beat = -1;

        drop_beat = 1;
        drop_cycles = 3;
        run_cmd(3'b011, 5'd0, 3'd2, 1'b1, 32'h200);
        chk("regrant_addr", obs_addr[2], 32'h208);
        chk("regrant_trans", obs_trans[2], 2'b10);
        chk("regrant_burst", obs_burst[2], 3'b001);
        chk("regrant_tail_trans", obs_trans[3], 2'b11);
        chk("regrant_tail_burst", obs_burst[3], 3'b001);
        chk("pre_drop_burst", obs_burst[1], 3'b011);
        drop_beat = -1;

        abort_beat = 5;
        run_cmd(3'b111, 5'd0, 3'd2, 1'b1, 32'h400);
        abort_beat = -1;
        #2;
        Hresetn = 1'b0;
        #1;
        check_reset("async_reset");
        model_reset();
        gcnt = 0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        repeat (4) one_cycle(1'b0);
        run_cmd(3'b011, 5'd0, 3'd2, 1'b0, 32'h300);
        chk("post_reset_addr0", obs_addr[0], 32'h300);
        chk("post_reset_addr3", obs_addr[3], 32'h30C);

        rnd_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [2:0] rs;
            rs = 3'($urandom_range(0, 2));
            run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 16)), rs,
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << rs);
            repeat ($urandom_range(0, 2)) one_cycle(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
